// File: rtl/cp0_exc_ctrl_pkg.sv
// CP0 exception controller shared definitions:
// register numbers, ExcCodes, bit-field positions.
package cp0_exc_ctrl_pkg;

    localparam logic [4:0] CP0_SR    = 5'd12;
    localparam logic [4:0] CP0_CAUSE = 5'd13;
    localparam logic [4:0] CP0_EPC   = 5'd14;
    localparam logic [4:0] CP0_PRID  = 5'd15;

    localparam logic [4:0] EXC_INT  = 5'd0;
    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;
    localparam logic [4:0] EXC_RI   = 5'd10;
    localparam logic [4:0] EXC_OV   = 5'd12;

    localparam logic [31:0] HANDLER_PC_DEF = 32'h0000_4180;
    localparam logic [31:0] PRID_DEF       = 32'h4D49_5053;

    localparam int SR_IE     = 0;
    localparam int SR_EXL    = 1;
    localparam int SR_IM_LO  = 10;
    localparam int SR_IM_HI  = 15;

    localparam int CAUSE_EXC_LO = 2;
    localparam int CAUSE_EXC_HI = 6;
    localparam int CAUSE_IP_LO  = 10;
    localparam int CAUSE_IP_HI  = 15;
    localparam int CAUSE_BD     = 31;

endpackage

// File: rtl/cp0_exc_ctrl_if.sv
// M-stage <-> CP0 bundle: exception/interrupt inputs,
// mtc0/eret requests, read data and redirect outputs.
interface cp0_exc_ctrl_if;

    logic [31:0] m_pc;
    logic        m_bd;
    logic        m_exc_valid;
    logic [4:0]  m_exc_code;
    logic [5:0]  hw_int;
    logic        m_mtc0;
    logic        m_eret;
    logic [4:0]  m_cp0_addr;
    logic [31:0] m_wdata;

    logic [31:0] rdata;
    logic        exc_req;
    logic        eret_req;
    logic [31:0] epc_out;
    logic [31:0] exc_pc;

    modport master (
        output m_pc, m_bd, m_exc_valid, m_exc_code, hw_int,
        output m_mtc0, m_eret, m_cp0_addr, m_wdata,
        input  rdata, exc_req, eret_req, epc_out, exc_pc
    );

    modport slave (
        input  m_pc, m_bd, m_exc_valid, m_exc_code, hw_int,
        input  m_mtc0, m_eret, m_cp0_addr, m_wdata,
        output rdata, exc_req, eret_req, epc_out, exc_pc
    );

endinterface

// File: rtl/cp0_exc_ctrl_int_arb.sv
// Interrupt vs exception arbitration; interrupt wins
// and reports ExcCode 0.
module cp0_int_arb
    import cp0_exc_ctrl_pkg::*;
(
    input  logic [5:0] hw_int_i,
    input  logic [5:0] im_i,
    input  logic       ie_i,
    input  logic       exl_i,
    input  logic       exc_valid_i,
    input  logic [4:0] exc_code_i,
    output logic       take_o,
    output logic [4:0] code_o
);

    logic int_req;
    logic exc_only;

    // Masked, enabled interrupt beats a pending M-stage exception
    always_comb begin
        int_req  = (|(hw_int_i & im_i)) & ie_i & ~exl_i;
        exc_only = exc_valid_i & ~exl_i;
        take_o   = int_req | exc_only;
        code_o   = int_req ? EXC_INT : exc_code_i;
    end

endmodule

// File: rtl/cp0_exc_ctrl.sv
// CP0 SR/Cause/EPC state, exception entry, eret return
// and mtc0 writes for the M stage.
module cp0_exc_ctrl
    import cp0_exc_ctrl_pkg::*;
#(
    parameter logic [31:0] HANDLER_PC = HANDLER_PC_DEF,
    parameter logic [31:0] PRID_VAL   = PRID_DEF
) (
    input  logic           clk,
    input  logic           reset,
    cp0_exc_ctrl_if.slave  bus
);

    logic [5:0]  im_q, im_d;
    logic        exl_q, exl_d;
    logic        ie_q, ie_d;
    logic        bd_q, bd_d;
    logic [5:0]  ip_q, ip_d;
    logic [4:0]  code_q, code_d;
    logic [29:0] epc_q, epc_d;

    logic        take;
    logic [4:0]  arb_code;
    logic [31:0] sr_w;
    logic [31:0] cause_w;
    logic [31:0] epc_w;
    logic        unused_ok;

    cp0_int_arb u_arb (
        .hw_int_i    (bus.hw_int),
        .im_i        (im_q),
        .ie_i        (ie_q),
        .exl_i       (exl_q),
        .exc_valid_i (bus.m_exc_valid),
        .exc_code_i  (bus.m_exc_code),
        .take_o      (take),
        .code_o      (arb_code)
    );

    assign unused_ok = ^bus.m_pc[1:0];

    assign sr_w    = {16'b0, im_q, 8'b0, exl_q, ie_q};
    assign cause_w = {bd_q, 15'b0, ip_q, 3'b0, code_q, 2'b0};
    assign epc_w   = {epc_q, 2'b0};

    // Redirect requests; both held low while reset is asserted
    always_comb begin
        bus.exc_req  = take & ~reset;
        bus.eret_req = bus.m_eret & ~take & ~reset;
        bus.epc_out  = epc_w;
        bus.exc_pc   = HANDLER_PC;
    end

    // Combinational CP0 read of the pre-edge registers
    always_comb begin
        bus.rdata = 32'b0;
        case (bus.m_cp0_addr)
            CP0_SR:    bus.rdata = sr_w;
            CP0_CAUSE: bus.rdata = cause_w;
            CP0_EPC:   bus.rdata = epc_w;
            CP0_PRID:  bus.rdata = PRID_VAL;
            default:   bus.rdata = 32'b0;
        endcase
    end

    // Next state: exception entry drops any eret/mtc0
    always_comb begin
        im_d   = im_q;
        exl_d  = exl_q;
        ie_d   = ie_q;
        bd_d   = bd_q;
        code_d = code_q;
        epc_d  = epc_q;
        ip_d   = bus.hw_int;
        if (bus.exc_req) begin
            exl_d  = 1'b1;
            bd_d   = bus.m_bd;
            code_d = arb_code;
            epc_d  = bus.m_pc[31:2] - {29'd0, bus.m_bd};
        end else begin
            if (bus.eret_req) begin
                exl_d = 1'b0;
            end
            if (bus.m_mtc0) begin
                case (bus.m_cp0_addr)
                    CP0_SR: begin
                        im_d  = bus.m_wdata[SR_IM_HI:SR_IM_LO];
                        exl_d = bus.m_wdata[SR_EXL];
                        ie_d  = bus.m_wdata[SR_IE];
                    end
                    CP0_EPC: epc_d = bus.m_wdata[31:2];
                    default: ;
                endcase
            end
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            im_q   <= '0;
            exl_q  <= 1'b0;
            ie_q   <= 1'b0;
            bd_q   <= 1'b0;
            ip_q   <= '0;
            code_q <= '0;
            epc_q  <= '0;
        end else begin
            im_q   <= im_d;
            exl_q  <= exl_d;
            ie_q   <= ie_d;
            bd_q   <= bd_d;
            ip_q   <= ip_d;
            code_q <= code_d;
            epc_q  <= epc_d;
        end
    end

endmodule

// File: doc/cp0_exc_ctrl.md
Name: cp0_exc_ctrl

Overview:
Coprocessor-0 exception/interrupt controller for the 5-stage MIPS32 pipeline. It consumes the M-stage exception code produced by the M-stage exception checker, the hardware interrupt lines and M-stage mtc0/eret requests. It arbitrates interrupt against exception, updates the SR, Cause and EPC registers, and issues a one-cycle flush/redirect to the exception handler or back to EPC. It sits beside the M stage and feeds the PC-select and pipeline-flush logic.

Parameters:
HANDLER_PC, 32'h0000_4180, exception/interrupt entry address
PRID_VAL, 32'h4D49_5053, read-only PRId (reg 15) value

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
m_pc  in  32  PC of the M-stage slot; bubbles carry the PC of the next real instruction
m_bd  in  1  M-stage instruction is in a branch delay slot
m_exc_valid  in  1  M-stage exception present
m_exc_code  in  [6:2]  M-stage ExcCode (4 AdEL, 5 AdES, 10 RI, 12 Ov)
hw_int  in  [7:2]  hardware interrupt lines, level-sensitive
m_mtc0  in  1  mtc0 in M stage
m_eret  in  1  eret in M stage
m_cp0_addr  in  5  CP0 register number for mtc0/mfc0
m_wdata  in  32  mtc0 write data
rdata  out  32  combinational read of CP0[m_cp0_addr]
exc_req  out  1  take exception/interrupt this cycle: flush F/D/E/M, redirect to HANDLER_PC
eret_req  out  1  redirect to epc_out this cycle, flush younger stages
epc_out  out  32  current EPC value

Behaviour:
- Registers: SR = {16'b0, IM[15:10], 8'b0, EXL[1], IE[0]}, all other bits read 0. Cause = {BD[31], 15'b0, IP[15:10], 3'b0, ExcCode[6:2], 2'b0}. EPC is a 32-bit register with [1:0] forced to 0.
- Reset: SR, Cause and EPC are 0. exc_req and eret_req are 0 in the reset cycle.
- int_req = |(hw_int & IM) & IE & ~EXL.
- exc_only = m_exc_valid & ~EXL.
- exc_req = int_req | exc_only. This is combinational, so it takes effect in the same cycle as the M-stage inputs.
- Priority: interrupt beats exception. On interrupt, Cause.ExcCode <= 0. Otherwise Cause.ExcCode <= m_exc_code.
- On an exc_req edge:
  - EXL <= 1
  - Cause.BD <= m_bd
  - EPC <= m_bd ? m_pc-4 : m_pc, computed in 32-bit wrap-around arithmetic with [1:0] cleared
- Cause.IP <= hw_int every cycle, independent of masks and EXL.
- eret_req = m_eret & ~exc_req. On an eret_req edge, EXL <= 0. epc_out is the pre-edge EPC, so the redirect target is valid in the same cycle.
- mtc0 writes on the edge only when m_mtc0 & ~exc_req:
  - addr 12: IM, EXL and IE are written from the same bit positions of m_wdata.
  - addr 14: EPC <= {m_wdata[31:2], 2'b0}.
  - addr 13, addr 15 and all others: the write is ignored.
- Simultaneous events:
  - exc_req and mtc0: the mtc0 is dropped.
  - exc_req and eret: the exception wins and EXL stays 1.
  - Interrupt asserted while EXL=1: held pending and taken on the first cycle after eret clears EXL, if still asserted.
- rdata: 12→SR, 13→Cause, 14→EPC, 15→PRID_VAL, others→0. There is no write-to-read bypass; the value read is the pre-edge register.
- Reset mid-handler: all state is cleared, and no stale exc_req or eret_req occurs in the following cycle.
- exc_req and eret_req are never high in the same cycle.

Decomposition:
- Shared package holds:
  - CP0 register numbers (SR=12, CAUSE=13, EPC=14, PRID=15)
  - ExcCode constants (INT=0, ADEL=4, ADES=5, RI=10, OV=12)
  - HANDLER_PC default
  - SR and Cause bit-field index constants
- Optional sub-module: cp0_int_arb, which holds the combinational int_req/exc_only/priority/ExcCode selection. Registers stay in cp0_exc_ctrl.

Test Plan:
- Reset, then read addr 12/13/14/15 → 0, 0, 0, 32'h4D49_5053; exc_req=0.
- mtc0 SR=32'h0000_FC01 (IM all, IE=1), then hw_int=6'b000100 with m_pc=32'h0000_3010, m_bd=0:
  - same cycle: exc_req=1
  - next cycle: EPC=32'h0000_3010, Cause=32'h0000_1000, SR.EXL=1
  - while hw_int held: exc_req=0
- m_exc_valid=1, code=12, m_bd=1, m_pc=32'h0000_3008, with SR IE=0 → exc_req=1; EPC=32'h0000_3004, Cause.BD=1, ExcCode=12.
- With EXL=1, assert m_eret and hold hw_int[2] with IE=1:
  - eret cycle: eret_req=1, epc_out=EPC
  - next cycle: exc_req=1
- Same cycle: m_exc_valid=1 (code 4), m_mtc0 to addr 14 with 32'hDEAD_BEEF, m_eret=1 → exc_req=1, eret_req=0; EPC=m_pc, not written by mtc0; EXL=1.
- Assert reset while EXL=1 with hw_int active → next cycle: SR=0, EPC=0, exc_req=0.
